otter_fetch_queue: RTL and testbench

OTTER_FETCH_QUEUE -- requirements
Module: otter_fetch_queue

---
 rtl/otter_fetch_queue_if.sv | 27 ++
 rtl/otter_fetch_queue.sv | 113 +++++++++++
 tb/tb_otter_fetch_queue.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/otter_fetch_queue_if.sv
// Fetch-queue bus: memory port 1 request/response plus the decode-side handshake.
interface otter_fetch_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [31:0]   mem_addr1;
    logic          mem_read1;
    logic [31:0]   mem_dout1;
    logic          if_valid;
    logic [31:0]   if_ir;
    logic [31:0]   if_pc;
    logic          de_ready;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic [CW-1:0] if_count;

    modport master (
        output mem_addr1, mem_read1, if_valid, if_ir, if_pc, if_count,
        input  mem_dout1, de_ready, redirect, redirect_pc
    );

    modport slave (
        input  mem_addr1, mem_read1, if_valid, if_ir, if_pc, if_count,
        output mem_dout1, de_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/otter_fetch_queue.sv
// Instruction fetch unit: issues sequential fetches and buffers {pc, ir} in a circular queue
// ahead of decode, with redirect flush and one-cycle drain of a word already in flight.
module otter_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    otter_fetch_queue_if.master   io_bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_inflight_pc;
    logic          r_inflight;
    logic [31:0]   r_q_pc [DEPTH];
    logic [31:0]   r_q_ir [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic          w_read;
    logic          w_push;
    logic          w_pop;
    logic          w_flush;
    logic          w_valid;
    logic [CW-1:0] w_occupancy;
    logic [31:0]   w_redirect_pc;

    assign w_valid       = (r_count != '0);
    assign w_occupancy   = r_count + CW'(r_inflight);
    assign w_redirect_pc = io_bus.redirect_pc & ~32'h0000_0003;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_BOOT;
        else       r_state <= w_state_nxt;
    end

    // Next state and handshake decisions; the returning word is the one requested last cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_read      = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            S_BOOT: w_state_nxt = S_RUN;
            S_RUN: begin
                w_read  = !io_bus.redirect && (w_occupancy < CW'(DEPTH));
                w_push  = r_inflight && !io_bus.redirect;
                w_pop   = w_valid && io_bus.de_ready && !io_bus.redirect;
                w_flush = io_bus.redirect;
                if (io_bus.redirect && r_inflight) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: w_state_nxt = S_RUN;
            default: w_state_nxt = S_BOOT;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_q_pc        <= '{default: '0};
            r_q_ir        <= '{default: '0};
        end else begin
            r_inflight <= w_read;
            if (w_read) r_inflight_pc <= r_fetch_pc;

            if (io_bus.redirect) r_fetch_pc <= w_redirect_pc;
            else if (w_read)     r_fetch_pc <= r_fetch_pc + 32'd4;

            if (w_flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_q_pc[r_wptr] <= r_inflight_pc;
                    r_q_ir[r_wptr] <= io_bus.mem_dout1;
                    r_wptr         <= r_wptr + PW'(1);
                end
                if (w_pop) r_rptr <= r_rptr + PW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    // The issue throttle must make this unreachable.
    always_ff @(posedge i_clk) begin
        if (!i_rst) assert (!(w_push && !w_pop && (r_count == CW'(DEPTH))));
    end

    assign io_bus.mem_addr1 = r_fetch_pc;
    assign io_bus.mem_read1 = w_read;
    assign io_bus.if_valid  = w_valid;
    assign io_bus.if_ir     = r_q_ir[r_rptr];
    assign io_bus.if_pc     = r_q_pc[r_rptr];
    assign io_bus.if_count  = r_count;
endmodule

// File: tb/tb_otter_fetch_queue.sv
// Directed bench for otter_fetch_queue; the memory model answers each address with addr+0x100.
module tb_otter_fetch_queue;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    otter_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    otter_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.mem_dout1 <= bus.mem_addr1 + 32'h100;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.de_ready    = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;

        // reset values
        @(negedge clk);
        chk("rst_read",  32'(bus.mem_read1), 32'h0);
        chk("rst_addr",  bus.mem_addr1,      32'h0);
        chk("rst_valid", 32'(bus.if_valid),  32'h0);
        chk("rst_count", 32'(bus.if_count),  32'h0);
        chk("rst_ir",    bus.if_ir,          32'h0);
        chk("rst_pc",    bus.if_pc,          32'h0);

        // streaming with decode always ready
        rst = 1'b0;
        chk("boot_read", 32'(bus.mem_read1), 32'h0);
        cyc(1);
        chk("c1_read", 32'(bus.mem_read1), 32'h1);
        chk("c1_addr", bus.mem_addr1,      32'h0);
        cyc(1);
        chk("c2_valid", 32'(bus.if_valid), 32'h0);
        chk("c2_addr",  bus.mem_addr1,     32'h4);
        cyc(1);
        chk("c3_valid", 32'(bus.if_valid), 32'h1);
        chk("c3_pc",    bus.if_pc,         32'h0);
        chk("c3_ir",    bus.if_ir,         32'h100);
        cyc(1);
        chk("c4_pc",    bus.if_pc,         32'h4);
        chk("c4_ir",    bus.if_ir,         32'h104);
        chk("c4_count", 32'(bus.if_count), 32'h1);
        cyc(1);
        chk("c5_pc",    bus.if_pc,         32'h8);

        // back-pressure: fill to DEPTH then stop fetching
        rst = 1'b1;
        bus.de_ready = 1'b0;
        cyc(1);
        rst = 1'b0;
        cyc(1);
        chk("bp1_addr", bus.mem_addr1, 32'h0);
        cyc(3);
        chk("bp4_read",  32'(bus.mem_read1), 32'h1);
        chk("bp4_addr",  bus.mem_addr1,      32'hC);
        chk("bp4_count", 32'(bus.if_count),  32'h2);
        cyc(1);
        chk("bp5_read",  32'(bus.mem_read1), 32'h0);
        cyc(2);
        chk("bp7_count", 32'(bus.if_count),  32'h4);
        chk("bp7_read",  32'(bus.mem_read1), 32'h0);
        chk("bp7_pc",    bus.if_pc,          32'h0);
        bus.de_ready = 1'b1;
        cyc(1);
        chk("bp8_count", 32'(bus.if_count),  32'h3);
        chk("bp8_pc",    bus.if_pc,          32'h4);
        chk("bp8_read",  32'(bus.mem_read1), 32'h1);
        chk("bp8_addr",  bus.mem_addr1,      32'h10);
        bus.de_ready = 1'b0;

        // redirect with 3 queued and one word in flight
        cyc(1);
        chk("rd0_count", 32'(bus.if_count), 32'h3);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h201;
        #1;
        chk("rd0_read", 32'(bus.mem_read1), 32'h0);
        cyc(1);
        bus.redirect = 1'b0;
        chk("rd1_count", 32'(bus.if_count),  32'h0);
        chk("rd1_valid", 32'(bus.if_valid),  32'h0);
        chk("rd1_drain", 32'(bus.mem_read1), 32'h0);
        cyc(1);
        chk("rd2_read", 32'(bus.mem_read1), 32'h1);
        chk("rd2_addr", bus.mem_addr1,      32'h200);
        cyc(1);
        chk("rd3_valid", 32'(bus.if_valid), 32'h0);
        cyc(1);
        chk("rd4_valid", 32'(bus.if_valid), 32'h1);
        chk("rd4_pc",    bus.if_pc,         32'h200);
        chk("rd4_ir",    bus.if_ir,         32'h300);

        // redirect coinciding with a pop, into the address-wrap region
        bus.de_ready    = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFF8;
        cyc(1);
        bus.redirect = 1'b0;
        chk("rp1_count", 32'(bus.if_count), 32'h0);
        chk("rp1_valid", 32'(bus.if_valid), 32'h0);
        chk("rp1_addr",  bus.mem_addr1,     32'hFFFF_FFF8);
        cyc(1);
        chk("rp2_read",  32'(bus.mem_read1), 32'h1);
        chk("rp2_addr",  bus.mem_addr1,      32'hFFFF_FFF8);
        chk("rp2_valid", 32'(bus.if_valid),  32'h0);
        cyc(1);
        chk("rp3_addr",  bus.mem_addr1,      32'hFFFF_FFFC);
        chk("rp3_valid", 32'(bus.if_valid),  32'h0);
        cyc(1);
        chk("rp4_addr", bus.mem_addr1, 32'h0);
        chk("rp4_pc",   bus.if_pc,     32'hFFFF_FFF8);
        chk("rp4_ir",   bus.if_ir,     32'h0000_00F8);
        cyc(1);
        chk("rp5_pc",   bus.if_pc,     32'hFFFF_FFFC);
        cyc(1);
        chk("rp6_pc",   bus.if_pc,     32'h0);
        chk("rp6_ir",   bus.if_ir,     32'h100);

        // reset pulse mid-operation with 3 queued
        rst = 1'b1;
        bus.de_ready = 1'b0;
        cyc(1);
        rst = 1'b0;
        cyc(5);
        chk("mr_count_pre", 32'(bus.if_count), 32'h3);
        rst = 1'b1;
        #1;
        chk("mr_valid", 32'(bus.if_valid),  32'h0);
        chk("mr_count", 32'(bus.if_count),  32'h0);
        chk("mr_read",  32'(bus.mem_read1), 32'h0);
        chk("mr_ir",    bus.if_ir,          32'h0);
        chk("mr_pc",    bus.if_pc,          32'h0);
        cyc(1);
        rst = 1'b0;
        bus.de_ready = 1'b1;
        cyc(1);
        chk("mr1_addr",  bus.mem_addr1,     32'h0);
        cyc(1);
        chk("mr2_valid", 32'(bus.if_valid), 32'h0);
        cyc(1);
        chk("mr3_valid", 32'(bus.if_valid), 32'h1);
        chk("mr3_pc",    bus.if_pc,         32'h0);
        chk("mr3_ir",    bus.if_ir,         32'h100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
